// File: rtl/fir_decimator.sv
// Block-averaging decimator for the FIR output stream: sums 2^LOG2_DECIM valid
// samples, rounds to the mean and queues results in a small valid/ready FIFO.
module fir_decimator #(
   parameter int DIN_W      = 7,
   parameter int LOG2_DECIM = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clr,
   input  logic                          din_valid,
   input  logic signed [DIN_W-1:0]       din,
   output logic signed [DIN_W-1:0]       dout,
   output logic                          dout_valid,
   input  logic                          dout_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);
   localparam int ACC_W = DIN_W + LOG2_DECIM;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic signed [ACC_W-1:0] HALF = ACC_W'(2 ** (LOG2_DECIM - 1));

   logic signed [ACC_W-1:0]           acc;
   logic        [LOG2_DECIM-1:0]      cnt;
   logic signed [ACC_W-1:0]           din_ext, sum, rnd, avg;
   logic        [FIFO_DEPTH-1:0][DIN_W-1:0] mem;
   logic        [PTR_W-1:0]           wr_ptr, rd_ptr;
   logic                              blk_done, push, pop, full, push_ok, drop;

   assign din_ext  = {{LOG2_DECIM{din[DIN_W-1]}}, din};
   assign sum      = acc + din_ext;
   // Sum of in-range samples plus half an LSB still fits ACC_W, so no guard bit.
   assign rnd      = sum + HALF;
   assign avg      = rnd >>> LOG2_DECIM;

   assign blk_done = din_valid && (&cnt);
   assign push     = blk_done && !clr;
   assign pop      = dout_valid && dout_ready && !clr;
   assign full     = (fifo_count == CNT_W'(FIFO_DEPTH));
   assign push_ok  = push && (!full || pop);
   assign drop     = push && full && !pop;

   assign dout_valid = (fifo_count != '0);
   assign dout       = dout_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc        <= '0;
         cnt        <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else if (clr) begin
         acc        <= '0;
         cnt        <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (din_valid) begin
            acc <= blk_done ? '0 : sum;
            cnt <= cnt + LOG2_DECIM'(1);
         end
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         if (push_ok && !pop)      fifo_count <= fifo_count + CNT_W'(1);
         else if (!push_ok && pop) fifo_count <= fifo_count - CNT_W'(1);
         if (drop) overflow <= 1'b1;
      end
   end

   // Storage needs no reset: dout is masked to zero while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= avg[DIN_W-1:0];
   end
endmodule

// File: doc/fir_decimator.md
Name: fir_decimator

Overview:
- Downstream consumer of the 3-tap FIR filter output.
- Takes the filter's 7-bit signed Q4 result stream and averages each block of 2^LOG2_DECIM valid samples with rounding.
- Buffers the decimated results in a small FIFO.
- Presents results on a valid/ready interface to the next stage (display or serial link).

Parameters:
- DIN_W, 7, input and output sample width; signed, 4 fractional bits (Q4).
- LOG2_DECIM, 2, log2 of the decimation factor; DECIM = 4 by default, legal range 1..4.
- FIFO_DEPTH, 4, number of result entries; power of two, at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- clr  input  1  synchronous clear of accumulator, FIFO and overflow flag.
- din_valid  input  1  din carries a sample this cycle.
- din  input  DIN_W  signed Q4 sample from the FIR filter.
- dout  output  DIN_W  signed Q4 decimated result, taken from the FIFO head.
- dout_valid  output  1  FIFO is not empty.
- dout_ready  input  1  consumer accepts dout this cycle.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.
- overflow  output  1  sticky; a result was dropped because the FIFO was full.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - accumulator, sample counter, FIFO pointers and fifo_count go to 0.
  - dout = 0, dout_valid = 0, overflow = 0.
- Accumulation:
  - Accumulator is signed, DIN_W+LOG2_DECIM bits wide; the sample counter is LOG2_DECIM bits.
  - Each cycle with din_valid = 1, din is sign-extended and added, and the counter increments.
  - Cycles with din_valid = 0 change nothing; gaps between samples are allowed.
- Block completion:
  - Occurs on the cycle where din_valid = 1 and counter = DECIM-1.
  - sum = acc + din.
  - result = (sum + 2^(LOG2_DECIM-1)) >>> LOG2_DECIM, an arithmetic shift (round half toward +inf), truncated to DIN_W bits.
  - result cannot exceed the DIN_W range: the average of in-range values stays in range, so no saturation logic is needed.
  - At the same clock edge, the accumulator and counter return to 0 and the result is pushed into the FIFO.
- Latency: the result is visible at dout, with dout_valid = 1, one cycle after the edge that samples the DECIM-th input, provided the FIFO was empty.
- FIFO and output handshake:
  - dout always reflects the head entry; dout = 0 when empty.
  - A transfer occurs when dout_valid && dout_ready; the head pops at that edge.
  - While dout_valid = 1 and dout_ready = 0, dout must stay stable.
  - dout_ready while empty has no effect.
- Push and pop interaction:
  - A push is accepted if fifo_count < FIFO_DEPTH, or if a pop occurs in the same cycle. Full + simultaneous pop + push means the push is accepted and count stays at FIFO_DEPTH.
  - A push when full with no pop drops the result, leaves FIFO contents and pointers unchanged, and sets overflow = 1 at that edge.
  - Simultaneous push and pop when not full leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Clear (clr = 1):
  - At the next edge, clears the accumulator, counter, FIFO (count = 0, dout_valid = 0) and overflow.
  - Has priority over din_valid and dout_ready in the same cycle: that sample is discarded and no pop is counted.
- Reset or clr mid-block discards the partial sum; the next valid sample starts a new block.
- overflow clears only on rst_n or clr.

Test Plan:
- Reset then idle → dout = 0, dout_valid = 0, fifo_count = 0, overflow = 0. Assert rst_n low mid-block with FIFO at 2 → all outputs 0 immediately, no clock needed.
- dout_ready = 1; din = 16,16,16,16 (1.0) with a 2-cycle din_valid gap after the second sample → dout = 16 with dout_valid for exactly one cycle, starting the cycle after the 4th sample.
- Rounding and extremes:
  - 1,2,0,0 → 1.
  - -1,-2,0,0 → -1.
  - 2,0,0,0 → 1 (half rounds up).
  - -2,0,0,0 → 0.
  - 63×4 → 63.
  - -64×4 → -64.
- Backpressure: dout_ready = 0; 5 blocks averaging 1,2,3,4,5 → fifo_count = 4, overflow = 1, block 5 dropped, dout held at 1. Then dout_ready = 1 → outputs 1,2,3,4 in consecutive cycles, then dout_valid = 0.
- Full plus simultaneous pop: FIFO full, dout_ready = 1 on the completion cycle of a 6th block (value 6) → fifo_count stays 4, overflow unchanged (0 after clr), 6 emerges last.
- clr asserted together with din_valid on the 4th sample and dout_ready = 1 with 2 entries queued → next cycle fifo_count = 0, overflow = 0. The next 4 samples of 8 produce dout = 8.
